// File: rtl/pipe_reg_skid_if.sv
// Valid/ready handshake bundle for the elastic pipeline register.
// The writer/reader side uses master; the buffer itself uses slave.
interface pipe_reg_skid_if #(
  parameter int n = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_data;
  logic [1:0]   count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_skid.sv
// Two-entry skid buffer: full-throughput elastic pipeline register.
// in_ready comes straight from the state register, so out_ready never reaches it combinationally.
module pipe_reg_skid #(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_reg_skid_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [n-1:0] main_data;
  logic [n-1:0] main_data_nxt;
  logic [n-1:0] skid_data;
  logic [n-1:0] skid_data_nxt;
  logic         push;
  logic         pop;

  // The state doubles as the occupancy: main is valid unless EMPTY, skid is valid only in FULL.
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_data;
  assign bus.count     = state;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_data_nxt;
      skid_data <= skid_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    main_data_nxt = main_data;
    skid_data_nxt = skid_data;
    if (bus.flush) begin
      // Any pop this cycle has already been seen by the reader; everything else is discarded.
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_nxt     = ONE;
            main_data_nxt = bus.in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data_nxt = bus.in_data;
          end else if (push) begin
            state_nxt     = FULL;
            skid_data_nxt = bus.in_data;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt     = ONE;
            main_data_nxt = skid_data;
            skid_data_nxt = '0;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Scoreboard bench for pipe_reg_skid: two instances (n=32, n=8) share control stimulus.
// The reference is an occupancy count plus FIFO queues of expected data.
module tb_pipe_reg_skid;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_reg_skid_if #(.n(32)) b32 ();
  pipe_reg_skid_if #(.n(8))  b8 ();

  pipe_reg_skid #(.n(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  pipe_reg_skid #(.n(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  logic [31:0] sb32[$];
  logic [7:0]  sb8[$];
  int occ  = 0;
  int vec  = 0;
  int bad  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic underflow(input string name);
    vec++;
    bad++;
    $display("FAIL %s: DUT popped an entry but none was expected (t=%0t)", name, $time);
  endtask

  // Monitor: mid-cycle, inputs and state are stable; compare handshake and popped data.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count32",     {30'd0, b32.count}, occ);
      chk("in_ready32",  {31'd0, b32.in_ready}, {31'd0, occ < 2});
      chk("out_valid32", {31'd0, b32.out_valid}, {31'd0, occ > 0});
      chk("count8",      {30'd0, b8.count}, occ);
      chk("out_valid8",  {31'd0, b8.out_valid}, {31'd0, occ > 0});
      if (b32.out_valid && b32.out_ready) begin
        if (sb32.size() == 0) underflow("pop32");
        else chk("data32", b32.out_data, sb32.pop_front());
      end
      if (b8.out_valid && b8.out_ready) begin
        if (sb8.size() == 0) underflow("pop8");
        else chk("data8", {24'd0, b8.out_data}, {24'd0, sb8.pop_front()});
      end
    end
  end

  // One clock of stimulus, called at posedge+1; returns at the following posedge+1.
  task automatic cyc(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
    int nxt;
    bit acc;
    b32.in_valid = iv;  b32.in_data = d;      b32.out_ready = ordy; b32.flush = fl;
    b8.in_valid  = iv;  b8.in_data  = d[7:0]; b8.out_ready  = ordy; b8.flush  = fl;
    acc = iv && (occ < 2);
    if (acc && !fl) begin
      sb32.push_back(d);
      sb8.push_back(d[7:0]);
    end
    if (fl) nxt = 0;
    else    nxt = occ + int'(acc) - int'(ordy && (occ > 0));
    @(posedge clk);
    #1;
    occ = nxt;
    if (fl) begin
      sb32.delete();
      sb8.delete();
    end
  endtask

  initial begin
    b32.in_valid = 1'b0; b32.in_data = '0; b32.out_ready = 1'b0; b32.flush = 1'b0;
    b8.in_valid  = 1'b0; b8.in_data  = '0; b8.out_ready  = 1'b0; b8.flush  = 1'b0;

    #12;
    chk("por_out_valid", {31'd0, b32.out_valid}, 32'd0);
    chk("por_in_ready",  {31'd0, b32.in_ready}, 32'd1);
    chk("por_count",     {30'd0, b32.count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset while FULL
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    chk("full_count", {30'd0, b32.count}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, b32.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, b32.in_ready}, 32'd1);
    chk("rst_count",     {30'd0, b32.count}, 32'd0);
    chk("rst_out_data",  b32.out_data, 32'd0);
    chk("rst_out_data8", {24'd0, b8.out_data}, 32'd0);
    occ = 0;
    sb32.delete();
    sb8.delete();
    #1 rst_n = 1'b1;
    cyc(1'b0, 32'd0, 1'b0, 1'b0);

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) cyc(1'b1, i, 1'b1, 1'b0);
    chk("stream_last", b32.out_data, 32'd8);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Backpressure fills the skid, then drains in order
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_count",    {30'd0, b32.count}, 32'd2);
    chk("bp_in_ready", {31'd0, b32.in_ready}, 32'd0);
    chk("bp_hold",     b32.out_data, 32'hA);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp_recover",  {31'd0, b32.in_ready}, 32'd1);
    chk("bp_second",   b32.out_data, 32'hB);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp_empty",    {31'd0, b32.out_valid}, 32'd0);

    // Simultaneous push and pop in ONE
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    chk("sim_first", b32.out_data, 32'h5);
    cyc(1'b1, 32'h6, 1'b1, 1'b0);
    chk("sim_data",  b32.out_data, 32'h6);
    chk("sim_count", {30'd0, b32.count}, 32'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush from FULL discards both entries
    cyc(1'b1, 32'h1, 1'b0, 1'b0);
    cyc(1'b1, 32'h2, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("flush_count", {30'd0, b32.count}, 32'd0);
    chk("flush_valid", {31'd0, b32.out_valid}, 32'd0);
    cyc(1'b1, 32'h33, 1'b1, 1'b0);
    chk("flush_next", b32.out_data, 32'h33);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
          $urandom_range(0, 99) < 3);
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("drain_sb32", sb32.size(), 32'd0);
    chk("drain_sb8",  sb8.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
